move_repeat_scheduler: RTL and testbench
========================================

# move_repeat_scheduler

Converts the four raw, already-synchronized direction buttons into the single-cycle `left`/`right`/`up`/`down` step commands consumed by `userPosition`. It arbitrates between simultaneously held buttons and emits one step on press. If the button is held, it emits a second step after a hold delay and then steps at a fixed repeat rate, so the cursor moves one cell per tap and glides when held. The block sits between the button synchronizers and `userPosition`, clocked from `CLOCK_50`.

## Interface
- `DELAY`, 25_000_000: cycles from the first step to the second step while held (0.5 s at 50 MHz); must be ≥1.
- `RATE`, 5_000_000: cycles between subsequent repeat steps while held (10 steps/s); must be ≥1.
- `CNT_W`, `$clog2(max(DELAY,RATE))+1`: hold counter width (derived, not overridden).
- `CLOCK_50` in 1: system clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset). One clock; reset is asynchronous and active-low.
- `enable` in 1: 1 = scheduling allowed; 0 = no steps, FSM forced to IDLE.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: level, active-high, synchronous to `CLOCK_50`.
- `up`, `down`, `left`, `right` out 1 each: registered one-cycle step pulses to `userPosition`; at most one high in any cycle.
- `active` out 1: registered; 1 while a direction is latched (states WAIT/REPEAT).
- `dir` out 2: registered latched direction, 0=up 1=down 2=left 3=right; 0 in IDLE.

## Operation
- States: IDLE, WAIT (hold delay), REPEAT (auto-repeat).
- IDLE:
  - If `enable`=1 and any button is high, latch the highest-priority held button (up > down > left > right) into `dir`.
  - Assert that step pulse for the next cycle, clear the counter, and go to WAIT.
  - Otherwise stay in IDLE with all pulses 0.
- WAIT, latched button still high and `enable`=1:
  - If `cnt`==DELAY-1: pulse, `cnt`←0, go to REPEAT.
  - Otherwise `cnt`←`cnt`+1, no pulse.
- REPEAT, latched button still high and `enable`=1:
  - If `cnt`==RATE-1: pulse, `cnt`←0.
  - Otherwise `cnt`←`cnt`+1, no pulse.
- Release: in WAIT or REPEAT, the latched button sampled low causes IDLE next cycle, with no pulse that cycle, even if the counter was at terminal value.
- Other buttons pressed or released while a direction is latched are ignored. They are re-arbitrated only from IDLE, which takes one edge after release.
- `enable`=0 at any edge: next state IDLE, all pulses 0, `cnt`←0, `active`←0.
- Counter is unsigned `CNT_W` bits and never wraps, because it is cleared at each terminal count.
- Wrap-around of the cursor position is `userPosition`'s job; this block is unaware of grid bounds.

## Timing
- Reset (`reset`=0) asynchronously forces:
  - state IDLE, `cnt`=0, `dir`=0, `active`=0;
  - `up`=`down`=`left`=`right`=0.
- Deassertion is synchronous to the next rising edge; the first edge with `reset`=1 may already register a press.
- Latency: button sampled high at edge E0 (state IDLE) → step pulse high from E0 to E1.
- Held continuously: pulses follow edges E0, E0+DELAY, E0+DELAY+RATE, E0+DELAY+2·RATE, …
- A pulse is exactly one cycle wide. With RATE=1 the pulse is high every cycle in REPEAT.
- Release sampled at edge Er → `active`=0 after Er; a new press can be sampled at Er+1 at the earliest.
- Reset mid-REPEAT: pulse drops immediately (asynchronously), and no pulse follows reset release unless a button is sampled high in IDLE.

## Test plan
(Bench overrides DELAY=4, RATE=2.)
- Reset with all buttons low, then 5 idle cycles → all pulses 0, `active`=0, `dir`=0 throughout.
- Tap: `btn_right` high for exactly 1 sampled edge → exactly one `right` pulse one cycle later, `dir`=3, return to IDLE; no further pulses over 10 cycles.
- Hold: `btn_down` sampled high at E0..E9 → `down` pulses after E0, E4, E6, E8 (4 total), `active` 0 after E10.
- Priority and lock:
  - `btn_left`+`btn_up` pressed together → only `up` pulses.
  - Releasing `btn_up` while `btn_left` is still held → IDLE for one edge, then a `left` pulse.
  - Pressing `btn_right` mid-hold has no effect.
- Enable gating: hold `btn_left` and drop `enable` in REPEAT for 3 cycles → no pulses, state IDLE. Raising `enable` → an immediate `left` pulse, then the next one 4 cycles later.
- Reset mid-operation: assert `reset`=0 between edges while in REPEAT with a pulse high → pulse and `active` go 0 immediately. After release with the button still held → fresh sequence starting with an immediate pulse.

Source files
------------

// File: rtl/move_repeat_scheduler.sv
// Turns held direction buttons into single-cycle step pulses: one step on press,
// a second after a hold delay, then steady auto-repeat until release.
module move_repeat_scheduler #(
    parameter int unsigned DELAY = 25_000_000,
    parameter int unsigned RATE  = 5_000_000,
    parameter int unsigned CNT_W = $clog2((DELAY > RATE) ? DELAY : RATE) + 1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       enable,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       active,
    output logic [1:0] dir
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        REPEAT
    } state_t;

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             any_btn;
    logic [1:0]       arb_dir;
    logic             held;

    // Pulse vector ordered {up, down, left, right}, indexed by direction code.
    function automatic logic [3:0] pulse_of(input logic [1:0] d);
        return 4'b1000 >> d;
    endfunction

    always_comb begin
        any_btn = btn_up | btn_down | btn_left | btn_right;
        arb_dir = 2'd3;
        if (btn_up)
            arb_dir = 2'd0;
        else if (btn_down)
            arb_dir = 2'd1;
        else if (btn_left)
            arb_dir = 2'd2;
        case (dir)
            2'd0:    held = btn_up;
            2'd1:    held = btn_down;
            2'd2:    held = btn_left;
            default: held = btn_right;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state                   <= IDLE;
            cnt                     <= '0;
            dir                     <= '0;
            active                  <= 1'b0;
            {up, down, left, right} <= '0;
        end else begin
            {up, down, left, right} <= '0;
            if (!enable) begin
                state  <= IDLE;
                cnt    <= '0;
                dir    <= '0;
                active <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (any_btn) begin
                            dir                     <= arb_dir;
                            {up, down, left, right} <= pulse_of(arb_dir);
                            cnt                     <= '0;
                            active                  <= 1'b1;
                            state                   <= WAIT;
                        end
                    end
                    WAIT, REPEAT: begin
                        // Release takes priority over a terminal count in the same cycle.
                        if (!held) begin
                            state  <= IDLE;
                            cnt    <= '0;
                            dir    <= '0;
                            active <= 1'b0;
                        end else if (cnt == ((state == WAIT) ? DELAY_LAST : RATE_LAST)) begin
                            {up, down, left, right} <= pulse_of(dir);
                            cnt                     <= '0;
                            state                   <= REPEAT;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        cnt    <= '0;
                        dir    <= '0;
                        active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_move_repeat_scheduler.sv
// Directed bench for move_repeat_scheduler with DELAY=4, RATE=2; expected
// values below are hand-derived edge by edge.
module tb_move_repeat_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       b_up, b_down, b_left, b_right;
    logic       up, down, left, right;
    logic       active;
    logic [1:0] dir;

    int vectors = 0;
    int miscompares = 0;

    move_repeat_scheduler #(
        .DELAY(4),
        .RATE (2)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .enable   (enable),
        .btn_up   (b_up),
        .btn_down (b_down),
        .btn_left (b_left),
        .btn_right(b_right),
        .up       (up),
        .down     (down),
        .left     (left),
        .right    (right),
        .active   (active),
        .dir      (dir)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] P_NONE  = 4'b0000;
    localparam logic [3:0] P_UP    = 4'b1000;
    localparam logic [3:0] P_DOWN  = 4'b0100;
    localparam logic [3:0] P_LEFT  = 4'b0010;
    localparam logic [3:0] P_RIGHT = 4'b0001;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare {active, dir, up, down, left, right} against the expectation.
    task automatic expect_out(input string tag, input logic a, input logic [1:0] d,
                              input logic [3:0] p);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {active, dir, up, down, left, right};
        exp = {a, d, p};
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (active,dir,u,d,l,r)", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b1;
        b_up    = 1'b0;
        b_down  = 1'b0;
        b_left  = 1'b0;
        b_right = 1'b0;

        // Reset, then idle cycles.
        tick();
        tick();
        expect_out("reset_state", 1'b0, 2'd0, P_NONE);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out($sformatf("idle_%0d", i), 1'b0, 2'd0, P_NONE);
        end

        // Tap right for one sampled edge.
        b_right = 1'b1;
        tick();
        expect_out("tap_pulse", 1'b1, 2'd3, P_RIGHT);
        b_right = 1'b0;
        tick();
        expect_out("tap_release", 1'b0, 2'd0, P_NONE);
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_out($sformatf("tap_quiet_%0d", i), 1'b0, 2'd0, P_NONE);
        end

        // Hold down, sampled high at E0..E9: pulses after E0, E4, E6, E8.
        b_down = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            expect_out($sformatf("hold_E%0d", k), 1'b1, 2'd1,
                       (k == 0 || k == 4 || k == 6 || k == 8) ? P_DOWN : P_NONE);
        end
        b_down = 1'b0;
        tick();
        expect_out("hold_E10_idle", 1'b0, 2'd0, P_NONE);

        // Left+up together: up wins and stays locked.
        b_left = 1'b1;
        b_up   = 1'b1;
        tick();
        expect_out("prio_E0", 1'b1, 2'd0, P_UP);
        tick();
        expect_out("prio_E1", 1'b1, 2'd0, P_NONE);
        b_right = 1'b1;
        tick();
        expect_out("lock_E2", 1'b1, 2'd0, P_NONE);
        tick();
        expect_out("lock_E3", 1'b1, 2'd0, P_NONE);
        // Release at what would be the terminal count: no pulse, back to IDLE.
        b_up = 1'b0;
        tick();
        expect_out("rel_E4_idle", 1'b0, 2'd0, P_NONE);
        tick();
        expect_out("rearb_E5_left", 1'b1, 2'd2, P_LEFT);
        for (int k = 6; k <= 9; k++) begin
            tick();
            expect_out($sformatf("left_E%0d", k), 1'b1, 2'd2, (k == 9) ? P_LEFT : P_NONE);
        end

        // Drop enable in REPEAT for three edges.
        enable = 1'b0;
        for (int k = 10; k <= 12; k++) begin
            tick();
            expect_out($sformatf("dis_E%0d", k), 1'b0, 2'd0, P_NONE);
        end
        enable = 1'b1;
        tick();
        expect_out("en_E13_left", 1'b1, 2'd2, P_LEFT);
        for (int k = 14; k <= 19; k++) begin
            tick();
            expect_out($sformatf("en_E%0d", k), 1'b1, 2'd2,
                       (k == 17 || k == 19) ? P_LEFT : P_NONE);
        end

        // Reset between edges while the E19 pulse is high.
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", 1'b0, 2'd0, P_NONE);
        tick();
        expect_out("reset_held", 1'b0, 2'd0, P_NONE);
        rst_n = 1'b1;
        tick();
        expect_out("post_reset_E0", 1'b1, 2'd2, P_LEFT);
        for (int k = 1; k <= 4; k++) begin
            tick();
            expect_out($sformatf("post_reset_E%0d", k), 1'b1, 2'd2,
                       (k == 4) ? P_LEFT : P_NONE);
        end
        b_left  = 1'b0;
        b_right = 1'b0;
        tick();
        expect_out("final_idle", 1'b0, 2'd0, P_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
